// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and index helpers for the radix-2 DIT FFT.
// The fixed-point widths are consumed by the butterfly datapath, not by the sequencer.
package fft_pkg;

    localparam int LOG2N    = 5;
    localparam int N        = 1 << LOG2N;
    localparam int bits     = 16;
    localparam int fix_bit  = 7;
    localparam int BITREV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CALC   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    // Reverses the low w bits of v; shifting avoids variable bit indexing.
    function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v, input int w);
        logic [BITREV_W-1:0] r;
        logic [BITREV_W-1:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < BITREV_W; i++) begin
            if (i < w) begin
                r = {r[BITREV_W-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Signal bundle between the FFT sequencer (master) and the host, RAM and butterfly datapath.
// Strobes only, no backpressure: IN_VALID high in LOAD consumes one sample that cycle; OUT_VALID marks one RAM word.
interface fft_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = fft_pkg::LOG2N
);

    logic             START;
    logic             IN_VALID;
    logic             LD_WE;
    logic [LOG2N-1:0] LD_ADDR;
    logic             RD_EN;
    logic [LOG2N-1:0] RD_ADDR_A;
    logic [LOG2N-1:0] RD_ADDR_B;
    logic [LOG2N-2:0] TW_IDX;
    logic             WR_EN;
    logic [LOG2N-1:0] WR_ADDR_A;
    logic [LOG2N-1:0] WR_ADDR_B;
    logic [2:0]       STAGE;
    logic [LOG2N-1:0] OUT_RD_ADDR;
    logic             OUT_VALID;
    logic             OUT_LAST;
    logic             BUSY;
    logic             DONE;
    state_t           DBG_STATE;

    modport master (
        input  START, IN_VALID,
        output LD_WE, LD_ADDR, RD_EN, RD_ADDR_A, RD_ADDR_B, TW_IDX,
               WR_EN, WR_ADDR_A, WR_ADDR_B, STAGE, OUT_RD_ADDR,
               OUT_VALID, OUT_LAST, BUSY, DONE, DBG_STATE
    );

    modport slave (
        output START, IN_VALID,
        input  LD_WE, LD_ADDR, RD_EN, RD_ADDR_A, RD_ADDR_B, TW_IDX,
               WR_EN, WR_ADDR_A, WR_ADDR_B, STAGE, OUT_RD_ADDR,
               OUT_VALID, OUT_LAST, BUSY, DONE, DBG_STATE
    );

endinterface

// File: rtl/fft_bf_addr_gen.sv
// Maps (stage, butterfly index) to the in-place operand pair and twiddle ROM index.
// Purely combinational; the caller gates the results with its read strobe.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = fft_pkg::LOG2N
) (
    input  logic [2:0]       stage_i,
    input  logic [LOG2N-2:0] k_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_idx_o
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;

    // Bits above the stage move up one place to open a zero at bit s; B sets that bit.
    always_comb begin
        k_ext    = {1'b0, k_i};
        span     = LOG2N'(1) << stage_i;
        mask     = span - LOG2N'(1);
        addr_a_o = ((k_ext & ~mask) << 1) | (k_ext & mask);
        addr_b_o = addr_a_o | span;
        tw_idx_o = (k_i & mask[LOG2N-2:0]) << (3'(LOG2N - 1) - stage_i);
    end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for the in-place radix-2 DIT FFT: bit-reversed load, staged
// butterfly issue with write-back delay line, then natural-order unload.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N      = fft_pkg::LOG2N,
    parameter int BF_LATENCY = 2
) (
    input  logic            CLK,
    input  logic            RST,
    fft_sequencer_if.master bus
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int KW   = LOG2N - 1;
    localparam int BW   = $clog2(BF_LATENCY + 1);
    localparam int UW   = LOG2N + 1;

    typedef struct packed {
        logic             en;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } wb_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] c_q, c_d;
    logic [2:0]       s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             bar_q, bar_d;
    logic [BW-1:0]    bar_cnt_q, bar_cnt_d;
    logic [UW-1:0]    u_q, u_d;
    logic             out_valid_q;
    logic             out_last_q;
    wb_t              line_q [BF_LATENCY];

    logic             rd_en;
    logic             u_strobe;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [KW-1:0]    gen_tw;
    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;
    logic [KW-1:0]    rd_tw;

    fft_bf_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage_i  (s_q),
        .k_i      (k_q),
        .addr_a_o (gen_a),
        .addr_b_o (gen_b),
        .tw_idx_o (gen_tw)
    );

    always_comb begin
        rd_en    = (state_q == ST_CALC) && !bar_q;
        u_strobe = (state_q == ST_UNLOAD) && (u_q < UW'(N));
        rd_a     = rd_en ? gen_a  : '0;
        rd_b     = rd_en ? gen_b  : '0;
        rd_tw    = rd_en ? gen_tw : '0;
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        s_d       = s_q;
        k_d       = k_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        u_d       = u_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.START) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.IN_VALID) begin
                    c_d = c_q + LOG2N'(1);
                    if (c_q == LOG2N'(N - 1)) state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!bar_q) begin
                    k_d = k_q + KW'(1);
                    if (k_q == KW'(HALF - 1)) begin
                        bar_d     = 1'b1;
                        bar_cnt_d = '0;
                    end
                end else if (bar_cnt_q == BW'(BF_LATENCY - 1)) begin
                    // Stage advances only once the last write-back of this stage has landed.
                    bar_d     = 1'b0;
                    bar_cnt_d = '0;
                    if (s_q == 3'(LOG2N - 1)) begin
                        s_d     = '0;
                        state_d = ST_UNLOAD;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end else begin
                    bar_cnt_d = bar_cnt_q + BW'(1);
                end
            end
            ST_UNLOAD: begin
                // One extra cycle after the last address lets OUT_VALID/DONE drain while BUSY.
                if (u_strobe) begin
                    u_d = u_q + UW'(1);
                end else begin
                    u_d     = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            c_q         <= '0;
            s_q         <= '0;
            k_q         <= '0;
            bar_q       <= 1'b0;
            bar_cnt_q   <= '0;
            u_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            s_q         <= s_d;
            k_q         <= k_d;
            bar_q       <= bar_d;
            bar_cnt_q   <= bar_cnt_d;
            u_q         <= u_d;
            out_valid_q <= u_strobe;
            out_last_q  <= u_strobe && (u_q == UW'(N - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BF_LATENCY; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= {rd_en, rd_a, rd_b};
            for (int i = 1; i < BF_LATENCY; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign bus.LD_WE       = (state_q == ST_LOAD) && bus.IN_VALID;
    assign bus.LD_ADDR     = LOG2N'(bitrev(BITREV_W'(c_q), LOG2N));
    assign bus.RD_EN       = rd_en;
    assign bus.RD_ADDR_A   = rd_a;
    assign bus.RD_ADDR_B   = rd_b;
    assign bus.TW_IDX      = rd_tw;
    assign bus.WR_EN       = line_q[BF_LATENCY-1].en;
    assign bus.WR_ADDR_A   = line_q[BF_LATENCY-1].a;
    assign bus.WR_ADDR_B   = line_q[BF_LATENCY-1].b;
    assign bus.STAGE       = s_q;
    assign bus.OUT_RD_ADDR = u_q[LOG2N-1:0];
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_LAST    = out_last_q;
    assign bus.DONE        = out_last_q;
    assign bus.BUSY        = (state_q != ST_IDLE);
    assign bus.DBG_STATE   = state_q;

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the in-place radix-2 decimation-in-time 32-point FFT. It owns the single shared butterfly datapath (complex multiply plus the sign-magnitude Adder/Subtractor pair) and the dual-port working RAM. It runs three phases:

- **Load:** writes samples into RAM in bit-reversed order.
- **Compute:** issues one butterfly per cycle with read and write-back addresses and the twiddle index, stalling between stages for datapath latency.
- **Unload:** reads results out in natural order.

It contains no arithmetic on sample data.

## Interface
Parameters:
- `LOG2N`, default 5 — log2 of FFT size; `N` = 1<<`LOG2N`.
- `BF_LATENCY`, default 2 — cycles from butterfly RAM read address to write-back of its results (≥1).

Ports:
- `CLK` — input, 1 bit. Single clock; all logic on rising edge.
- `RST` — input, 1 bit. Reset is synchronous and active-high.
- `START` — input, 1 bit. Begin a transform; sampled only in IDLE.
- `IN_VALID` — input, 1 bit. Sample present on the data bus this cycle; honoured only in LOAD.
- `LD_WE` — output, 1 bit. RAM write enable for the load sample.
- `LD_ADDR` — output, `LOG2N` bits. Bit-reversed load address.
- `RD_EN` — output, 1 bit. Butterfly operand read.
- `RD_ADDR_A`, `RD_ADDR_B` — output, `LOG2N` bits each. Butterfly top/bottom read addresses.
- `TW_IDX` — output, `LOG2N`-1 bits. Twiddle ROM index, aligned with `RD_EN`.
- `WR_EN` — output, 1 bit. Butterfly result write-back.
- `WR_ADDR_A`, `WR_ADDR_B` — output, `LOG2N` bits each. Write-back addresses.
- `STAGE` — output, 3 bits. Current compute stage (0..`LOG2N`-1).
- `OUT_RD_ADDR` — output, `LOG2N` bits. Natural-order unload read address.
- `OUT_VALID` — output, 1 bit. Unload data valid; the RAM read is one cycle behind `OUT_RD_ADDR`.
- `OUT_LAST` — output, 1 bit. Marks the final `OUT_VALID` beat.
- `BUSY` — output, 1 bit. High from the cycle after START acceptance until the transform completes.
- `DONE` — output, 1 bit. One-cycle pulse coincident with the final `OUT_VALID`.

## Operation
- **States:** IDLE → LOAD → CALC → UNLOAD → IDLE.
- **IDLE:**
  - `START`=1 moves to LOAD.
  - `IN_VALID` is ignored, including in the `START` cycle itself.
- **LOAD:**
  - Sample counter `c` runs 0..N-1 and increments only when `IN_VALID`=1; gaps are allowed.
  - `LD_WE`=`IN_VALID`, `LD_ADDR`=bitrev(`c`).
  - The N-th accepted sample moves the FSM to CALC.
- **CALC:**
  - Per stage `s`, butterfly counter `k` runs 0..N/2-1, one issue per cycle.
  - `span`=1<<`s`.
  - `A` = ((`k`>>`s`)<<(`s`+1)) | (`k` & (`span`-1)); `B` = `A`+`span`.
  - `TW_IDX` = (`k` & (`span`-1)) << (`LOG2N`-1-`s`).
  - After `k`=N/2-1, hold `RD_EN`=0 for `BF_LATENCY` cycles (stage barrier). The next stage's first read therefore lands one cycle after the previous stage's last write, which prevents read-after-write hazards.
  - After the barrier of stage `LOG2N`-1, move to UNLOAD.
- **Write-back:** a `BF_LATENCY`-deep shift line carries `{RD_EN, RD_ADDR_A, RD_ADDR_B}` to `{WR_EN, WR_ADDR_A, WR_ADDR_B}`.
- **UNLOAD:**
  - `OUT_RD_ADDR` = 0..N-1, one per cycle.
  - `OUT_VALID` is the one-cycle-delayed read strobe.
  - `OUT_LAST` and `DONE` are asserted on the beat for address N-1.
  - The FSM then returns to IDLE.
- **START while BUSY:** ignored.
- **RST at any time:**
  - FSM returns to IDLE; all counters clear.
  - The write-back shift line clears, so no pending `WR_EN` leaks out after reset.

## Timing
- **Reset values:** every output is 0. `STAGE`=0, all addresses 0, `BUSY`=0.
- **START:** `START` in cycle `t0` gives `BUSY`=1 from `t0`+1.
- **LOAD → CALC:** with the N-th sample accepted in cycle `t`, the first `RD_EN` is in `t`+1.
- **CALC length:** `LOG2N`·(N/2+`BF_LATENCY`) cycles. Defaults: 90 cycles, spanning `t`+1..`t`+90.
- **Write-back latency:** `WR_EN` follows `RD_EN` by exactly `BF_LATENCY` cycles. Default last write: `t`+90.
- **Unload (defaults):**
  - First `OUT_RD_ADDR`=0 at `t`+91; first `OUT_VALID` at `t`+92.
  - `OUT_LAST`/`DONE` at `t`+123.
  - `BUSY`=0 and IDLE at `t`+124.
- **STAGE:** changes on the first issue cycle of each new stage; it is held during the barrier.

## Structure
- **Shared package `fft_pkg`:**
  - `LOG2N`, `N`.
  - FSM state encoding (IDLE/LOAD/CALC/UNLOAD).
  - `bitrev` function.
  - Fixed-point constants `bits`=16 and `fix_bit`=7, shared with the datapath.
- **Sub-module `fft_bf_addr_gen`:** combinational mapping from (`s`, `k`) to (`A`, `B`, `TW_IDX`).
- **Top level:** the FSM, counters, the write-back delay line and unload sequencing live in `fft_sequencer`.

## Test plan
- **Reset and load:** reset, then `START`, then 32 back-to-back `IN_VALID`. Required:
  - `LD_ADDR` sequence 0,16,8,24,4,…,31.
  - First `RD_EN` one cycle after the 32nd sample.
- **Stage addressing:**
  - Stage 0, `k`=3 → `A`=6, `B`=7, `TW_IDX`=0.
  - Stage 2, `k`=5 → `A`=9, `B`=13, `TW_IDX`=4.
  - Stage 4, `k`=15 → `A`=15, `B`=31, `TW_IDX`=15.
- **Barrier and write-back:** `WR_EN` equals `RD_EN` delayed by 2 cycles, with matching addresses. Exactly 2 idle read cycles per stage; last `WR_EN` at `t`+90.
- **Gapped load and end of transform:** `IN_VALID` toggled every other cycle, plus `START` pulses during CALC. Required:
  - Load count is unaffected by the gaps; the `START` pulses are ignored.
  - `OUT_RD_ADDR` runs 0..31.
  - `OUT_LAST`=`DONE`=1 on exactly one cycle.
  - `BUSY` falls on the next cycle.
- **Reset mid-stage:** `RST` during stage 2 with writes in flight. Required:
  - No `WR_EN` in any following cycle.
  - All outputs 0.
  - A fresh `START` completes correctly.
